dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/rd_tag_pipe.sv | 36 +++
 rtl/dmem_arbiter.sv | 98 +++++++++
 tb/tb_dmem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Port ids double as the round-robin last-grant encoding.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef struct packed {
        logic valid;
        logic port_id;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// In-flight read tag shift register; the tail lines up with the cycle
// dmem returns the data for the read that entered DEPTH cycles earlier.
module rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tail_o
);

    rd_tag_t stage_q [DEPTH];
    rd_tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a synchronous-read single-port dmem between
// the CPU load/store path (port 0) and an auxiliary master (port 1).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0] data_sh_q, data_sh_d;
    logic              any_gnt, win, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    rd_tag_t           tag_in, tag_tail;

    // Under contention port 0 wins unless it was the last port served.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && (!req1 || last_grant_q == PORT_AUX)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        any_gnt   = gnt0 | gnt1;
        win       = gnt1 ? PORT_AUX : PORT_CPU;
        sel_addr  = win ? addr1 : addr0;
        sel_wdata = win ? wdata1 : wdata0;
        sel_we    = win ? we1 : we0;

        address_dmem = any_gnt ? sel_addr : addr_sh_q;
        data         = any_gnt ? sel_wdata : data_sh_q;
        wren         = any_gnt & sel_we;

        addr_sh_d    = address_dmem;
        data_sh_d    = data;
        last_grant_d = any_gnt ? win : last_grant_q;

        tag_in.valid   = any_gnt & ~sel_we;
        tag_in.port_id = win;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= PORT_AUX;
            addr_sh_q    <= '0;
            data_sh_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            addr_sh_q    <= addr_sh_d;
            data_sh_q    <= data_sh_d;
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk_i  (clock),
        .rst_i  (reset),
        .tag_i  (tag_in),
        .tail_o (tag_tail)
    );

    assign rvalid0 = tag_tail.valid & (tag_tail.port_id == PORT_CPU);
    assign rvalid1 = tag_tail.valid & (tag_tail.port_id == PORT_AUX);
    assign rdata0  = q_dmem;
    assign rdata1  = q_dmem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LATENCY 1 and 3) share stimulus,
// each with its own dmem model; expected reads are queued and matched on return.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int NI   = 2;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;

    logic        gnt0_w [NI];
    logic        gnt1_w [NI];
    logic        rvalid0_w [NI];
    logic        rvalid1_w [NI];
    logic [31:0] rdata0_w [NI];
    logic [31:0] rdata1_w [NI];
    logic [11:0] addr_w [NI];
    logic [31:0] data_w [NI];
    logic        wren_w [NI];
    logic [31:0] q_w [NI];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        exp_last;
    logic [11:0] sh_addr;
    logic [31:0] sh_data;
    logic [31:0] ref_mem [int];
    exp_t        sb0_q [$];
    exp_t        sb1_q [$];

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int a);
        return 32'hA500_0000 ^ (a * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] exp_word(input logic [11:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_word(int'(a));
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 0) ? LAT0 : LAT1;
        logic [31:0] mem [4096];
        logic [31:0] rd_pipe [LAT];

        dmem_arbiter #(
            .ADDR_W     (12),
            .DATA_W     (32),
            .RD_LATENCY (LAT)
        ) u_dut (
            .clock        (clock),
            .reset        (reset),
            .req0         (req0),
            .we0          (we0),
            .addr0        (addr0),
            .wdata0       (wdata0),
            .gnt0         (gnt0_w[g]),
            .rvalid0      (rvalid0_w[g]),
            .rdata0       (rdata0_w[g]),
            .req1         (req1),
            .we1          (we1),
            .addr1        (addr1),
            .wdata1       (wdata1),
            .gnt1         (gnt1_w[g]),
            .rvalid1      (rvalid1_w[g]),
            .rdata1       (rdata1_w[g]),
            .address_dmem (addr_w[g]),
            .data         (data_w[g]),
            .wren         (wren_w[g]),
            .q_dmem       (q_w[g])
        );

        initial begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
        end

        // Synchronous-read dmem with read-old-data on a same-cycle write.
        always @(posedge clock) begin
            if (wren_w[g]) mem[addr_w[g]] <= data_w[g];
            rd_pipe[0] <= mem[addr_w[g]];
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end

        assign q_w[g] = rd_pipe[LAT-1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_ret(input int k);
        exp_t e;
        logic hit;
        hit = 1'b0;
        if (k == 0 && sb0_q.size() > 0 && sb0_q[0].due == cyc) begin
            e = sb0_q.pop_front();
            hit = 1'b1;
        end
        if (k == 1 && sb1_q.size() > 0 && sb1_q[0].due == cyc) begin
            e = sb1_q.pop_front();
            hit = 1'b1;
        end
        chk($sformatf("i%0d rvalid0", k), 64'(rvalid0_w[k]), 64'(hit && e.port == 1'b0));
        chk($sformatf("i%0d rvalid1", k), 64'(rvalid1_w[k]), 64'(hit && e.port == 1'b1));
        if (hit) begin
            chk($sformatf("i%0d rdata", k), 64'(e.port ? rdata1_w[k] : rdata0_w[k]),
                64'(e.data));
        end
    endtask

    // Called mid-cycle: checks grants, memory drive and returns, then advances the model.
    task automatic eval();
        logic        any, win, s_we;
        logic [11:0] s_addr;
        logic [31:0] s_wdata;
        exp_t        e;
        any = req0 | req1;
        if (req0 && req1) win = ~exp_last;
        else              win = req1;
        s_addr  = win ? addr1 : addr0;
        s_wdata = win ? wdata1 : wdata0;
        s_we    = win ? we1 : we0;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("i%0d gnt0", k), 64'(gnt0_w[k]), 64'(any && !win));
            chk($sformatf("i%0d gnt1", k), 64'(gnt1_w[k]), 64'(any && win));
            chk($sformatf("i%0d address", k), 64'(addr_w[k]), 64'(any ? s_addr : sh_addr));
            chk($sformatf("i%0d data", k), 64'(data_w[k]), 64'(any ? s_wdata : sh_data));
            chk($sformatf("i%0d wren", k), 64'(wren_w[k]), 64'(any && s_we));
            check_ret(k);
        end
        if (any) begin
            sh_addr  = s_addr;
            sh_data  = s_wdata;
            exp_last = win;
            if (s_we) begin
                ref_mem[int'(s_addr)] = s_wdata;
            end else begin
                e.port = win;
                e.data = exp_word(s_addr);
                e.due  = cyc + LAT0;
                sb0_q.push_back(e);
                e.due  = cyc + LAT1;
                sb1_q.push_back(e);
            end
        end
    endtask

    task automatic step(input logic r0, input logic w0, input logic [11:0] a0,
                        input logic [31:0] d0, input logic r1, input logic w1,
                        input logic [11:0] a1, input logic [31:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        @(negedge clock);
        eval();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    endtask

    task automatic chk_reset_outs(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s i%0d gnt0", tag, k), 64'(gnt0_w[k]), 64'(0));
            chk($sformatf("%s i%0d gnt1", tag, k), 64'(gnt1_w[k]), 64'(0));
            chk($sformatf("%s i%0d wren", tag, k), 64'(wren_w[k]), 64'(0));
            chk($sformatf("%s i%0d rvalid0", tag, k), 64'(rvalid0_w[k]), 64'(0));
            chk($sformatf("%s i%0d rvalid1", tag, k), 64'(rvalid1_w[k]), 64'(0));
            chk($sformatf("%s i%0d address", tag, k), 64'(addr_w[k]), 64'(0));
            chk($sformatf("%s i%0d data", tag, k), 64'(data_w[k]), 64'(0));
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        exp_last = 1'b1;
        sh_addr = '0;
        sh_data = '0;
        #2;
        chk_reset_outs("por");
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;

        // Lone port 0 read.
        step(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0);
        idle(3);

        // Port 1 write then port 0 read of the same word.
        step(0, 0, 12'h0, 32'h0, 1, 1, 12'h020, 32'hDEAD_BEEF);
        step(1, 0, 12'h020, 32'h0, 0, 0, 12'h0, 32'h0);
        idle(3);

        // Continuous contention, all reads.
        for (int i = 0; i < 6; i++) step(1, 0, 12'h030, 32'h0, 1, 0, 12'h040, 32'h0);
        idle(4);

        // Write to 0x055 then idle: shadowed address/data must hold.
        step(1, 1, 12'h055, 32'h1234_5678, 0, 0, 12'h0, 32'h0);
        idle(3);

        // Port 1 read granted, then reset before it returns.
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 1; we1 = 0; addr1 = 12'h077; wdata1 = '0;
        @(negedge clock);
        eval();
        #1 reset = 1'b1;
        #1;
        chk_reset_outs("rst");
        sb0_q.delete();
        sb1_q.delete();
        exp_last = 1'b1;
        sh_addr = '0;
        sh_data = '0;
        req1 = 0;
        @(posedge clock);
        #1;
        cyc++;
        chk_reset_outs("rst_hold");
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
        idle(3);

        // First contended cycle after reset goes to port 0.
        step(1, 0, 12'h066, 32'h0, 1, 0, 12'h067, 32'h0);
        step(1, 0, 12'h068, 32'h0, 1, 0, 12'h067, 32'h0);
        idle(4);

        // Back-to-back port 0 reads.
        step(1, 0, 12'h001, 32'h0, 0, 0, 12'h0, 32'h0);
        step(1, 0, 12'h002, 32'h0, 0, 0, 12'h0, 32'h0);
        step(1, 0, 12'h003, 32'h0, 0, 0, 12'h0, 32'h0);
        idle(4);

        // Random mix on a small address window.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 12'h0F0 + 12'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 12'h0F0 + 12'($urandom_range(0, 7)), $urandom);
        end
        idle(5);

        chk("sb0_drained", 64'(sb0_q.size()), 64'(0));
        chk("sb1_drained", 64'(sb1_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
